bist_sig_analyzer: RTL and testbench
====================================

# bist_sig_analyzer

BIST pattern-generation and response-compaction stage that sits directly downstream of the BIST controller. It consumes the controller's `init`/`running`/`finish` strobes, drives an LFSR pseudo-random pattern into the circuit under test (CUT), and compacts the CUT response into a MISR signature. When the run completes it compares that signature against a golden value and reports `done`/`pass`, which hold until the next run.

## Interface
- `WIDTH`, 8: pattern, response and signature width; minimum 2.
- `LFSR_POLY`, 8'hB8: LFSR tap mask; bit i set means stage i feeds the XOR.
- `MISR_POLY`, 8'hB8: MISR tap mask, same convention.
- `SEED`, 8'h01: LFSR load value on init/reset; must be non-zero.
- `GOLDEN`, 8'h00: expected final signature.
- `NCYCLES`, 5: expected number of compaction cycles.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `init` in 1: one-cycle strobe from the controller; starts a run.
- `running` in 1: compaction enable, level from the controller.
- `finish` in 1: one-cycle strobe from the controller; ends the run.
- `cut_resp` in WIDTH: CUT response to `pattern`, combinational, same cycle.
- `pattern` out WIDTH: current LFSR state driven to the CUT.
- `signature` out WIDTH: current MISR state.
- `cycle_count` out 8: compaction cycles counted this run; saturates at 255.
- `done` out 1: result valid; sticky.
- `pass` out 1: result; meaningful only while `done`=1.

## Operation
- States: IDLE, ARMED, COMPACT, COMPARE, DONE. All are registered.
- Reset (async) gives: state=IDLE, `pattern`=SEED, `signature`=0, `cycle_count`=0, `done`=0, `pass`=0.
- `init` is honoured in every state and has priority over `running` and `finish` in the same cycle.
  - On `init`: LFSR←SEED, MISR←0, count←0, `done`←0, `pass`←0, state→ARMED.
- ARMED: `running`=1 → state→COMPACT and that cycle compacts (see the update rule). `finish`=1 → state→COMPARE.
- COMPACT: each cycle with `running`=1 compacts.
  - MISR ← {misr[W-2:0], ^(misr & MISR_POLY)} ^ `cut_resp`.
  - LFSR ← {lfsr[W-2:0], ^(lfsr & LFSR_POLY)}.
  - count ← count+1, saturating at 255.
  - With `running`=0, all registers hold.
  - `finish`=1 → state→COMPARE with no compaction that cycle.
- COMPARE: `pass` ← (MISR==GOLDEN) && (count==NCYCLES); `done`←1; state→DONE.
- DONE: all outputs hold until `init` or `reset`. `running` and `finish` are ignored.
- In IDLE, `running` and `finish` are ignored; no result is ever produced without a prior `init`.
- Arithmetic: the tap XOR is a reduction over the masked bits, and `cut_resp` is XORed across the full WIDTH. The count increment is 8-bit saturating, not modulo.

## Timing
- `pattern` changes on the clock edge that ends each compaction cycle. The CUT response to pattern k is sampled on that same edge.
- The first pattern of a run is SEED, present from the cycle after `init`.
- The `finish` edge moves the state to COMPARE. `done`/`pass` assert on the following edge, i.e. 2 cycles after the `finish` cycle.
- `reset` mid-run aborts immediately and asynchronously; the result is lost.
- `init` mid-run restarts cleanly on the next edge.
- `init` while DONE clears `done` on the next edge.
- The controller's `toggle` output is not consumed by this block.

## Structure
- Package `bist_pkg` holds:
  - the state enum `bist_sa_state_t`;
  - the default poly/seed constants;
  - the count width constant (8).
- Sub-module `bist_shreg`: a WIDTH-bit feedback shift register with ports `load`, `load_val`, `en`, `poly`, `din`. It is instantiated twice:
  - as the LFSR, with `din`=0;
  - as the MISR, with `din`=`cut_resp` and `load_val`=0.

## Test plan
WIDTH=4, POLY=4'b1001, SEED=4'b0001.
- Reset → `pattern`=0001, `signature`=0000, `done`=0, `pass`=0, `cycle_count`=0.
- `init`, then `running` for 4 cycles with `cut_resp` tied to `pattern` → `pattern` steps 0001→0011→0111→1111→1110, `signature` steps 0001→0000→0111→0000, `cycle_count`=4.
- As above but 3 cycles, GOLDEN=0111, NCYCLES=3, then `finish` → 2 cycles later `done`=1, `pass`=1. Both hold for 10 idle cycles with `running`/`finish` toggling.
- Same run with `cut_resp` bit0 forced to 1 on cycle 2 → `signature`≠0111, `done`=1, `pass`=0.
  - Correct signature with NCYCLES=4 → `pass`=0 (count mismatch).
- `init` and `finish` in the same cycle during COMPACT → state=ARMED, counters cleared, no `done`.
  - Async `reset` pulse mid-COMPACT (between edges) → outputs return to reset values immediately.
- `finish` and `running` in IDLE with no `init` → `done` stays 0.
  - 300 compaction cycles → `cycle_count`=255.

Source files
------------

// File: rtl/bist_sig_analyzer_pkg.sv
// Shared types and defaults for the BIST signature analyzer.
// Holds the FSM state enum, counter width and default polynomials.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_COMPACT,
    S_COMPARE,
    S_DONE
  } bist_sa_state_t;

  localparam int CNT_W = 8;

  localparam logic [7:0] DEF_LFSR_POLY = 8'hB8;
  localparam logic [7:0] DEF_MISR_POLY = 8'hB8;
  localparam logic [7:0] DEF_SEED      = 8'h01;
  localparam logic [7:0] DEF_GOLDEN    = 8'h00;
  localparam int         DEF_NCYCLES   = 5;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/bist_sig_analyzer_if.sv
// Controller/CUT-facing bundle of the BIST signature analyzer.
// master drives strobes and CUT response; slave is the analyzer.
interface bist_sa_if #(
  parameter int WIDTH = 8
);
  logic             init;
  logic             running;
  logic             finish;
  logic [WIDTH-1:0] cut_resp;
  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] signature;
  logic [7:0]       cycle_count;
  logic             done;
  logic             pass;

  modport master (
    output init, running, finish, cut_resp,
    input  pattern, signature, cycle_count,
    input  done, pass
  );

  modport slave (
    input  init, running, finish, cut_resp,
    output pattern, signature, cycle_count,
    output done, pass
  );
endinterface

// File: rtl/bist_sig_analyzer_shreg.sv
// Feedback shift register used as both LFSR (din=0) and MISR.
// Shifts left, feeding back the parity of the tapped bits.
module bist_shreg #(
  parameter int             W       = 8,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] poly,
  input  logic [W-1:0] din,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         fb;

  always_comb begin
    fb  = ^(q_q & poly);
    q_d = {q_q[W-2:0], fb} ^ din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= RST_VAL;
    end else if (load) begin
      q_q <= load_val;
    end else if (en) begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bist_sig_analyzer.sv
// BIST pattern generation and response compaction stage.
// LFSR drives the CUT, MISR compacts its response, FSM grades it.
module bist_sig_analyzer
  import bist_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(DEF_LFSR_POLY),
  parameter logic [WIDTH-1:0] MISR_POLY = WIDTH'(DEF_MISR_POLY),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEF_SEED),
  parameter logic [WIDTH-1:0] GOLDEN    = WIDTH'(DEF_GOLDEN),
  parameter int               NCYCLES   = DEF_NCYCLES
) (
  input  logic      clk,
  input  logic      reset,
  bist_sa_if.slave  bus
);

  bist_sa_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             load;
  logic             en;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] misr;

  bist_shreg #(
    .W       (WIDTH),
    .RST_VAL (SEED)
  ) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (SEED),
    .en       (en),
    .poly     (LFSR_POLY),
    .din      ('0),
    .q        (lfsr)
  );

  bist_shreg #(
    .W       (WIDTH),
    .RST_VAL ('0)
  ) u_misr (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val ('0),
    .en       (en),
    .poly     (MISR_POLY),
    .din      (bus.cut_resp),
    .q        (misr)
  );

  // finish wins over running so the finish cycle never compacts
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    load    = 1'b0;
    en      = 1'b0;
    if (bus.init) begin
      load    = 1'b1;
      cnt_d   = '0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      state_d = S_ARMED;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARMED, S_COMPACT: begin
          if (bus.finish) begin
            state_d = S_COMPARE;
          end else if (bus.running) begin
            en      = 1'b1;
            cnt_d   = sat_inc(cnt_q);
            state_d = S_COMPACT;
          end
        end
        S_COMPARE: begin
          pass_d  = (misr == GOLDEN) &&
                    (cnt_q == CNT_W'(NCYCLES));
          done_d  = 1'b1;
          state_d = S_DONE;
        end
        S_DONE: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.pattern     = lfsr;
  assign bus.signature   = misr;
  assign bus.cycle_count = cnt_q;
  assign bus.done        = done_q;
  assign bus.pass        = pass_q;

endmodule

// File: tb/tb_bist_sig_analyzer.sv
// Self-checking bench: directed test-plan runs plus random strobes,
// compared every cycle against a behavioural model.
module tb_bist_sig_analyzer;

  localparam int         W = 4;
  localparam logic [3:0] P = 4'b1001;
  localparam logic [3:0] S = 4'b0001;
  localparam logic [3:0] G = 4'b0111;

  logic clk = 1'b0;
  logic reset;
  logic init, running, finish;
  logic [W-1:0] fault;
  logic chk_on;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bist_sa_if #(.WIDTH(W)) b0 ();
  bist_sa_if #(.WIDTH(W)) b1 ();

  assign b0.init     = init;
  assign b0.running  = running;
  assign b0.finish   = finish;
  assign b0.cut_resp = b0.pattern ^ fault;
  assign b1.init     = init;
  assign b1.running  = running;
  assign b1.finish   = finish;
  assign b1.cut_resp = b1.pattern ^ fault;

  bist_sig_analyzer #(
    .WIDTH(W), .LFSR_POLY(P), .MISR_POLY(P),
    .SEED(S), .GOLDEN(G), .NCYCLES(3)
  ) u0 (.clk(clk), .reset(reset), .bus(b0.slave));

  bist_sig_analyzer #(
    .WIDTH(W), .LFSR_POLY(P), .MISR_POLY(P),
    .SEED(S), .GOLDEN(G), .NCYCLES(4)
  ) u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  typedef enum {M_IDLE, M_ARMED, M_RUN, M_CMP, M_DONE} ph_t;
  ph_t          mph;
  logic [W-1:0] ml, mm;
  int           mc;
  logic         md, mp0, mp1;

  function automatic logic [W-1:0] nxt(
    input logic [W-1:0] v, input logic [W-1:0] p);
    logic [W-1:0] r;
    int par;
    par = 0;
    for (int i = 0; i < W; i++)
      if (v[i] && p[i]) par = par ^ 1;
    r = v << 1;
    r[0] = par[0];
    return r;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mph <= M_IDLE; ml <= S; mm <= '0; mc <= 0;
      md <= 1'b0; mp0 <= 1'b0; mp1 <= 1'b0;
    end else if (init) begin
      mph <= M_ARMED; ml <= S; mm <= '0; mc <= 0;
      md <= 1'b0; mp0 <= 1'b0; mp1 <= 1'b0;
    end else begin
      case (mph)
        M_ARMED, M_RUN: begin
          if (finish) mph <= M_CMP;
          else if (running) begin
            mph <= M_RUN;
            ml  <= nxt(ml, P);
            mm  <= nxt(mm, P) ^ (ml ^ fault);
            mc  <= (mc < 255) ? mc + 1 : 255;
          end
        end
        M_CMP: begin
          md  <= 1'b1;
          mp0 <= (mm == G) && (mc == 3);
          mp1 <= (mm == G) && (mc == 4);
          mph <= M_DONE;
        end
        default: ;
      endcase
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on && !reset) begin
      chk("u0.pattern", 32'(b0.pattern), 32'(ml));
      chk("u0.signature", 32'(b0.signature), 32'(mm));
      chk("u0.count", 32'(b0.cycle_count), 32'(mc));
      chk("u0.done", 32'(b0.done), 32'(md));
      chk("u0.pass", 32'(b0.pass), 32'(mp0));
      chk("u1.done", 32'(b1.done), 32'(md));
      chk("u1.pass", 32'(b1.pass), 32'(mp1));
    end
  end

  task automatic step(input logic i, input logic r,
                      input logic f, input logic [W-1:0] ft);
    init = i; running = r; finish = f; fault = ft;
    @(posedge clk);
    #1;
    init = 1'b0; running = 1'b0; finish = 1'b0; fault = '0;
  endtask

  logic [3:0] ep [4];
  logic [3:0] es [4];

  initial begin
    ep = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};
    es = '{4'b0001, 4'b0000, 4'b0111, 4'b0000};
    chk_on = 1'b0;
    reset = 1'b1;
    init = 1'b0; running = 1'b0; finish = 1'b0; fault = '0;
    #12;
    chk("rst.pattern", 32'(b0.pattern), 32'h1);
    chk("rst.signature", 32'(b0.signature), 32'h0);
    chk("rst.count", 32'(b0.cycle_count), 32'h0);
    chk("rst.done", 32'(b0.done), 32'h0);
    chk("rst.pass", 32'(b0.pass), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk_on = 1'b1;

    for (int k = 0; k < 6; k++)
      step(1'b0, k[0], ~k[0], '0);
    chk("idle.done", 32'(b0.done), 32'h0);
    chk("idle.pattern", 32'(b0.pattern), 32'h1);

    step(1'b1, 1'b0, 1'b0, '0);
    chk("a.first_pattern", 32'(b0.pattern), 32'h1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0, '0);
      chk("a.pattern", 32'(b0.pattern), 32'(ep[k]));
      chk("a.signature", 32'(b0.signature), 32'(es[k]));
    end
    chk("a.count", 32'(b0.cycle_count), 32'd4);

    step(1'b1, 1'b0, 1'b0, '0);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("b.done_early", 32'(b0.done), 32'h0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("b.done", 32'(b0.done), 32'h1);
    chk("b.pass", 32'(b0.pass), 32'h1);
    chk("b.sig", 32'(b0.signature), 32'h7);
    chk("b.pass_n4", 32'(b1.pass), 32'h0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), '0);
      chk("b.hold_done", 32'(b0.done), 32'h1);
      chk("b.hold_pass", 32'(b0.pass), 32'h1);
    end

    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 4'b0001);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("c.sig", 32'(b0.signature), 32'h4);
    chk("c.done", 32'(b0.done), 32'h1);
    chk("c.pass", 32'(b0.pass), 32'h0);

    step(1'b1, 1'b0, 1'b0, '0);
    repeat (2) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b1, '0);
    chk("d.pattern", 32'(b0.pattern), 32'h1);
    chk("d.sig", 32'(b0.signature), 32'h0);
    chk("d.count", 32'(b0.cycle_count), 32'h0);
    repeat (3) step(1'b0, 1'b0, 1'b0, '0);
    chk("d.done", 32'(b0.done), 32'h0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("d.armed_run", 32'(b0.pattern), 32'h3);

    step(1'b0, 1'b1, 1'b0, '0);
    running = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("r.pattern", 32'(b0.pattern), 32'h1);
    chk("r.sig", 32'(b0.signature), 32'h0);
    chk("r.count", 32'(b0.cycle_count), 32'h0);
    running = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    step(1'b1, 1'b0, 1'b0, '0);
    repeat (300) step(1'b0, 1'b1, 1'b0, '0);
    chk("s.count", 32'(b0.cycle_count), 32'd255);
    step(1'b0, 1'b0, 1'b1, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("s.pass", 32'(b0.pass), 32'h0);

    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 29) == 0),
           ($urandom_range(0, 7) == 0) ?
             W'($urandom) : '0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
